// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared types and constants for the dual-rail link transmitter
package link_pkg;

    typedef enum logic {ENC_TP, ENC_FP} enc_t;
    typedef enum logic [1:0] {IDLE, DATA, RTZ} state_t;

    localparam int RAIL_NUM = 2;
    localparam logic [RAIL_NUM-1:0] SPACER = '0;

    // Four-phase level for bit v; also the two-phase toggle mask for v.
    function automatic logic [RAIL_NUM-1:0] rail_code(input logic v);
        return {v, ~v};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts at ptr_i
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            grant_vld_o
);

    always_comb begin
        logic [IDW-1:0] j;
        j           = '0;
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((int'(ptr_i) + k) % NREQ);
            if (!grant_vld_o && req_i[j]) begin
                grant_vld_o = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = j;
            end
        end
    end

endmodule

// File: rtl/link_arbiter_tx.sv
// rtl/link_arbiter_tx.sv - arbitrates NREQ requesters onto one dual-rail async link
module link_arbiter_tx
    import link_pkg::*;
#(
    parameter string ENC     = "TP",
    parameter int    WIDTH   = 8,
    parameter int    NREQ    = 4,
    parameter int    TIMEOUT = 1024,
    localparam int   IDW     = $clog2(NREQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]                req_ready,
    output logic [WIDTH-1:0][RAIL_NUM-1:0] out,
    input  logic                           ack_i,
    output logic                           busy,
    output logic [IDW-1:0]                 grant_id,
    output logic                           timeout_err
);

    localparam enc_t ENC_MODE = (ENC == "FP") ? ENC_FP : ENC_TP;
    localparam int   CNTW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                         state_q;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out_q, code_d;
    logic [NREQ-1:0]                ready_q;
    logic                           busy_q, ack_exp_q, timeout_err_q;
    logic [IDW-1:0]                 grant_id_q, ptr_q, ptr_d;
    logic                           ack_meta_q, ack_s_q;
    logic [CNTW-1:0]                cnt_q;
    logic [NREQ-1:0]                win_grant;
    logic [IDW-1:0]                 win_idx;
    logic                           win_vld, waiting;
    logic [WIDTH-1:0]               win_word;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (win_grant),
        .grant_idx_o (win_idx),
        .grant_vld_o (win_vld)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NREQ; i++)
            if (win_grant[i]) win_word = win_word | req_data[i];
        code_d = out_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (ENC_MODE == ENC_FP) code_d[b] = rail_code(win_word[b]);
            else                    code_d[b] = out_q[b] ^ rail_code(win_word[b]);
        end
    end

    assign ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    assign waiting = ((state_q == DATA) && (ack_s_q != ack_exp_q)) ||
                     ((state_q == RTZ) && ack_s_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ack_i;
            ack_s_q    <= ack_meta_q;
        end
    end

    // A non-waiting cycle is always a state transition, so clearing here restarts the count per wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else if (!waiting) begin
            cnt_q <= '0;
        end else if (TIMEOUT != 0) begin
            if (cnt_q != CNTW'(TIMEOUT))     cnt_q <= cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(TIMEOUT - 1)) timeout_err_q <= 1'b1;
        end
    end

    // No grant in the req_ready cycle: that is the mandatory idle cycle between words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            out_q      <= '0;
            ready_q    <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            ack_exp_q  <= 1'b1;
        end else begin
            ready_q <= '0;
            case (state_q)
                IDLE: if (win_vld && (ready_q == '0)) begin
                    out_q      <= code_d;
                    grant_id_q <= win_idx;
                    ptr_q      <= ptr_d;
                    busy_q     <= 1'b1;
                    state_q    <= DATA;
                end
                DATA: if (ack_s_q == ack_exp_q) begin
                    if (ENC_MODE == ENC_FP) begin
                        out_q   <= {WIDTH{SPACER}};
                        state_q <= RTZ;
                    end else begin
                        ack_exp_q           <= ~ack_exp_q;
                        ready_q[grant_id_q] <= 1'b1;
                        busy_q              <= 1'b0;
                        state_q             <= IDLE;
                    end
                end
                RTZ: if (!ack_s_q) begin
                    ready_q[grant_id_q] <= 1'b1;
                    busy_q              <= 1'b0;
                    state_q             <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out         = out_q;
    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_link_arbiter_tx.sv
// tb/tb_link_arbiter_tx.sv - directed bench for two-phase and four-phase link_arbiter_tx
module tb_link_arbiter_tx;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 tp_rst, tp_ack, tp_busy, tp_terr;
    logic [N-1:0]         tp_valid, tp_ready;
    logic [N-1:0][W-1:0]  tp_data;
    logic [W-1:0][1:0]    tp_out;
    logic [1:0]           tp_gid;

    logic                 fp_rst, fp_ack, fp_busy, fp_terr;
    logic [N-1:0]         fp_valid, fp_ready;
    logic [N-1:0][W-1:0]  fp_data;
    logic [W-1:0][1:0]    fp_out;
    logic [1:0]           fp_gid;

    link_arbiter_tx #(.ENC("TP"), .WIDTH(W), .NREQ(N), .TIMEOUT(16)) u_tp (
        .clk(clk), .rst(tp_rst), .req_valid(tp_valid), .req_data(tp_data),
        .req_ready(tp_ready), .out(tp_out), .ack_i(tp_ack), .busy(tp_busy),
        .grant_id(tp_gid), .timeout_err(tp_terr)
    );

    link_arbiter_tx #(.ENC("FP"), .WIDTH(W), .NREQ(N), .TIMEOUT(1024)) u_fp (
        .clk(clk), .rst(fp_rst), .req_valid(fp_valid), .req_data(fp_data),
        .req_ready(fp_ready), .out(fp_out), .ack_i(fp_ack), .busy(fp_busy),
        .grant_id(fp_gid), .timeout_err(fp_terr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rails(input logic [7:0] w);
        logic [15:0] r;
        for (int b = 0; b < 8; b++) begin
            r[2*b+1] = w[b];
            r[2*b]   = ~w[b];
        end
        return r;
    endfunction

    function automatic logic [7:0] dec(input logic [15:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[2*b+1];
        return r;
    endfunction

    // Caller holds valid; returns in the req_ready cycle.
    task automatic tp_xfer(input int id, input logic [7:0] w, input string tag);
        logic [15:0] prev;
        prev = tp_out;
        for (int i = 0; i < 20 && !tp_busy; i++) tick();
        check({tag, " busy"}, tp_busy, 1);
        check({tag, " gid"}, tp_gid, id);
        check({tag, " rails"}, tp_out ^ prev, rails(w));
        check({tag, " dec"}, dec(tp_out ^ prev), w);
        tp_ack = ~tp_ack;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tp_ready != '0) break;
        end
        check({tag, " ready"}, tp_ready, 1 << id);
        check({tag, " idle"}, tp_busy, 0);
    endtask

    task automatic fp_xfer(input int id, input logic [7:0] w, input logic [15:0] code,
                           input int dly, input string tag);
        for (int i = 0; i < 20 && !fp_busy; i++) tick();
        check({tag, " busy"}, fp_busy, 1);
        check({tag, " gid"}, fp_gid, id);
        check({tag, " code"}, fp_out, code);
        check({tag, " dec"}, dec(fp_out), w);
        #(dly);
        fp_ack = 1'b1;
        for (int i = 0; i < 30 && fp_out != '0; i++) tick();
        check({tag, " spacer"}, fp_out, 0);
        check({tag, " rtz no ready"}, fp_ready, 0);
        fp_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fp_ready != '0) break;
        end
        check({tag, " ready"}, fp_ready, 1 << id);
    endtask

    initial begin
        logic [15:0] hold;
        logic [3:0]  seen;
        tp_rst = 1'b1; fp_rst = 1'b1; tp_ack = 1'b0; fp_ack = 1'b0;
        tp_valid = '0; fp_valid = '0; tp_data = '0; fp_data = '0;
        #2;
        tp_rst = 1'b0; fp_rst = 1'b0;
        tick(); tick();
        check("rst tp out", tp_out, 0);
        check("rst tp busy", tp_busy, 0);
        check("rst tp terr", tp_terr, 0);
        check("rst fp out", fp_out, 0);
        check("rst fp ready", fp_ready, 0);
        check("rst fp gid", fp_gid, 0);
        tp_rst = 1'b1; fp_rst = 1'b1;
        tick();

        // All four requesters pending: order 0,1,2,3,0.
        tp_data[0] = 8'h11; tp_data[1] = 8'h22; tp_data[2] = 8'h33; tp_data[3] = 8'h44;
        tp_valid = 4'hF;
        tp_xfer(0, 8'h11, "rr0"); tp_data[0] = 8'h55;
        tp_xfer(1, 8'h22, "rr1");
        tp_xfer(2, 8'h33, "rr2");
        tp_xfer(3, 8'h44, "rr3");
        tp_xfer(0, 8'h55, "rr4");
        tp_valid = '0;
        tick();
        check("rr ready single", tp_ready, 0);

        tp_valid[2] = 1'b1;
        tp_data[2] = 8'h00; tp_xfer(2, 8'h00, "tp00"); tp_data[2] = 8'hFF;
        tick();
        tp_xfer(2, 8'hFF, "tpFF"); tp_data[2] = 8'h3C;
        tp_xfer(2, 8'h3C, "tp3C");
        tp_valid = '0;
        tick();
        check("tp no timeout", tp_terr, 0);

        fp_data[0] = 8'hA5; fp_valid[0] = 1'b1;
        fp_xfer(0, 8'hA5, 16'h9966, 137, "fpA5");
        fp_valid = '0;
        tick();
        check("fpA5 one pulse", fp_ready, 0);

        // Ack activity in IDLE must be ignored.
        fp_ack = 1'b1;
        repeat (4) tick();
        check("spur busy", fp_busy, 0);
        check("spur out", fp_out, 0);
        fp_ack = 1'b0;
        seen = '0;
        for (int i = 0; i < 4; i++) begin tick(); seen = seen | fp_ready; end
        check("spur ready", seen, 0);

        fp_data[2] = 8'h3C; fp_valid[2] = 1'b1;
        for (int i = 0; i < 20 && !fp_busy; i++) tick();
        check("pre-rst gid", fp_gid, 2);
        check("pre-rst code", fp_out, rails(8'h3C));
        fp_ack = 1'b1;
        for (int i = 0; i < 30 && fp_out != '0; i++) tick();
        check("pre-rst rtz busy", fp_busy, 1);
        #2;
        fp_rst = 1'b0; fp_ack = 1'b0;
        #1;
        check("rtz rst out", fp_out, 0);
        check("rtz rst busy", fp_busy, 0);
        check("rtz rst gid", fp_gid, 0);
        fp_valid = '0;
        tick(); tick();
        fp_rst = 1'b1;
        fp_data[1] = 8'h5A; fp_data[3] = 8'hC3; fp_valid = 4'b1010;
        fp_xfer(1, 8'h5A, rails(8'h5A), 0, "post-rst 5A");
        fp_valid[1] = 1'b0;
        fp_xfer(3, 8'hC3, rails(8'hC3), 0, "post-rst C3");
        fp_valid = '0;

        // Receiver never acks.
        tp_data[0] = 8'h81; tp_valid[0] = 1'b1;
        for (int i = 0; i < 20 && !tp_busy; i++) tick();
        check("to busy", tp_busy, 1);
        hold = tp_out;
        seen = '0;
        for (int i = 0; i < 15; i++) begin tick(); seen = seen | tp_ready; end
        check("to before", tp_terr, 0);
        tick();
        check("to at 16", tp_terr, 1);
        for (int i = 0; i < 10; i++) begin tick(); seen = seen | tp_ready; end
        check("to sticky", tp_terr, 1);
        check("to out held", tp_out, hold);
        check("to no ready", seen, 0);
        check("to still busy", tp_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
